// File: rtl/nasti_mux_arbiter.sv
// Index FIFO recording AW grant order so W beats can be steered to the right master.
// Latency: one cycle from push to head visibility (no bypass).
// Backpressure: full/empty flags; the caller must not push when full or pop when empty.
module nasti_mux_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]             cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign full     = (cnt_q == (PW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
endmodule

// Round-robin arbiter with grant lock: once a request is presented it is held until handshake.
// Latency: zero-cycle combinational grant; pointer advances past the winner on handshake.
// Backpressure: en=0 suppresses new grants; a held lock keeps its grant regardless of en.
module nasti_mux_rr #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic          hs,
    output logic [IW-1:0] gnt,
    output logic          gnt_vld
);
    logic          lock_q, lock_d;
    logic [IW-1:0] idx_q, idx_d, rr_q, rr_d;
    logic [IW-1:0] jj;
    logic          found;
    int            j;

    always_comb begin
        found = 1'b0;
        gnt   = idx_q;
        j     = 0;
        jj    = '0;
        if (lock_q) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                j = int'(rr_q) + k;
                if (j >= N) j = j - N;
                jj = IW'(j);
                if (!found && req[jj]) begin
                    found = 1'b1;
                    gnt   = jj;
                end
            end
        end
        gnt_vld = found && (en || lock_q);

        lock_d = lock_q;
        idx_d  = idx_q;
        rr_d   = rr_q;
        if (hs) begin
            lock_d = 1'b0;
            rr_d   = (gnt == IW'(N - 1)) ? '0 : gnt + IW'(1);
        end else if (gnt_vld) begin
            lock_d = 1'b1;
            idx_d  = gnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= 1'b0;
            idx_q  <= '0;
            rr_q   <= '0;
        end else begin
            lock_q <= lock_d;
            idx_q  <= idx_d;
            rr_q   <= rr_d;
        end
    end
endmodule

// Merges N_MASTER NASTI masters onto one slave: RR arbitration on AR/AW, W steered by AW order.
// Latency: zero-cycle combinational routing on every channel; W usable the cycle after its AW.
// Backpressure: readies pass straight through to the selected master; AW stalls when the W FIFO is full.
module nasti_mux_arbiter #(
    parameter int N_MASTER     = 2,
    parameter int ID_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int USER_WIDTH   = 1,
    parameter int W_FIFO_DEPTH = 4,
    localparam int IDX_W       = (N_MASTER > 2) ? $clog2(N_MASTER) : 1,
    localparam int SID_W       = ID_WIDTH + IDX_W,
    localparam int STRB_W      = DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    // master AR
    input  logic [N_MASTER-1:0]                   master_ar_valid,
    output logic [N_MASTER-1:0]                   master_ar_ready,
    input  logic [N_MASTER-1:0][ID_WIDTH-1:0]     master_ar_id,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]   master_ar_addr,
    input  logic [N_MASTER-1:0][7:0]              master_ar_len,
    input  logic [N_MASTER-1:0][2:0]              master_ar_size,
    input  logic [N_MASTER-1:0][1:0]              master_ar_burst,
    input  logic [N_MASTER-1:0]                   master_ar_lock,
    input  logic [N_MASTER-1:0][3:0]              master_ar_cache,
    input  logic [N_MASTER-1:0][2:0]              master_ar_prot,
    input  logic [N_MASTER-1:0][3:0]              master_ar_qos,
    input  logic [N_MASTER-1:0][3:0]              master_ar_region,
    input  logic [N_MASTER-1:0][USER_WIDTH-1:0]   master_ar_user,
    // master AW
    input  logic [N_MASTER-1:0]                   master_aw_valid,
    output logic [N_MASTER-1:0]                   master_aw_ready,
    input  logic [N_MASTER-1:0][ID_WIDTH-1:0]     master_aw_id,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]   master_aw_addr,
    input  logic [N_MASTER-1:0][7:0]              master_aw_len,
    input  logic [N_MASTER-1:0][2:0]              master_aw_size,
    input  logic [N_MASTER-1:0][1:0]              master_aw_burst,
    input  logic [N_MASTER-1:0]                   master_aw_lock,
    input  logic [N_MASTER-1:0][3:0]              master_aw_cache,
    input  logic [N_MASTER-1:0][2:0]              master_aw_prot,
    input  logic [N_MASTER-1:0][3:0]              master_aw_qos,
    input  logic [N_MASTER-1:0][3:0]              master_aw_region,
    input  logic [N_MASTER-1:0][USER_WIDTH-1:0]   master_aw_user,
    // master W
    input  logic [N_MASTER-1:0]                   master_w_valid,
    output logic [N_MASTER-1:0]                   master_w_ready,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]   master_w_data,
    input  logic [N_MASTER-1:0][STRB_W-1:0]       master_w_strb,
    input  logic [N_MASTER-1:0]                   master_w_last,
    input  logic [N_MASTER-1:0][USER_WIDTH-1:0]   master_w_user,
    // master R
    output logic [N_MASTER-1:0]                   master_r_valid,
    input  logic [N_MASTER-1:0]                   master_r_ready,
    output logic [N_MASTER-1:0][ID_WIDTH-1:0]     master_r_id,
    output logic [N_MASTER-1:0][DATA_WIDTH-1:0]   master_r_data,
    output logic [N_MASTER-1:0][1:0]              master_r_resp,
    output logic [N_MASTER-1:0]                   master_r_last,
    output logic [N_MASTER-1:0][USER_WIDTH-1:0]   master_r_user,
    // master B
    output logic [N_MASTER-1:0]                   master_b_valid,
    input  logic [N_MASTER-1:0]                   master_b_ready,
    output logic [N_MASTER-1:0][ID_WIDTH-1:0]     master_b_id,
    output logic [N_MASTER-1:0][1:0]              master_b_resp,
    output logic [N_MASTER-1:0][USER_WIDTH-1:0]   master_b_user,
    // slave AR
    output logic                                  slave_ar_valid,
    input  logic                                  slave_ar_ready,
    output logic [SID_W-1:0]                      slave_ar_id,
    output logic [ADDR_WIDTH-1:0]                 slave_ar_addr,
    output logic [7:0]                            slave_ar_len,
    output logic [2:0]                            slave_ar_size,
    output logic [1:0]                            slave_ar_burst,
    output logic                                  slave_ar_lock,
    output logic [3:0]                            slave_ar_cache,
    output logic [2:0]                            slave_ar_prot,
    output logic [3:0]                            slave_ar_qos,
    output logic [3:0]                            slave_ar_region,
    output logic [USER_WIDTH-1:0]                 slave_ar_user,
    // slave AW
    output logic                                  slave_aw_valid,
    input  logic                                  slave_aw_ready,
    output logic [SID_W-1:0]                      slave_aw_id,
    output logic [ADDR_WIDTH-1:0]                 slave_aw_addr,
    output logic [7:0]                            slave_aw_len,
    output logic [2:0]                            slave_aw_size,
    output logic [1:0]                            slave_aw_burst,
    output logic                                  slave_aw_lock,
    output logic [3:0]                            slave_aw_cache,
    output logic [2:0]                            slave_aw_prot,
    output logic [3:0]                            slave_aw_qos,
    output logic [3:0]                            slave_aw_region,
    output logic [USER_WIDTH-1:0]                 slave_aw_user,
    // slave W
    output logic                                  slave_w_valid,
    input  logic                                  slave_w_ready,
    output logic [DATA_WIDTH-1:0]                 slave_w_data,
    output logic [STRB_W-1:0]                     slave_w_strb,
    output logic                                  slave_w_last,
    output logic [USER_WIDTH-1:0]                 slave_w_user,
    // slave R
    input  logic                                  slave_r_valid,
    output logic                                  slave_r_ready,
    input  logic [SID_W-1:0]                      slave_r_id,
    input  logic [DATA_WIDTH-1:0]                 slave_r_data,
    input  logic [1:0]                            slave_r_resp,
    input  logic                                  slave_r_last,
    input  logic [USER_WIDTH-1:0]                 slave_r_user,
    // slave B
    input  logic                                  slave_b_valid,
    output logic                                  slave_b_ready,
    input  logic [SID_W-1:0]                      slave_b_id,
    input  logic [1:0]                            slave_b_resp,
    input  logic [USER_WIDTH-1:0]                 slave_b_user
);
    logic [IDX_W-1:0] ar_gnt, aw_gnt, w_head, r_idx, b_idx;
    logic             ar_gnt_vld, aw_gnt_vld;
    logic             w_full, w_empty, w_act, w_push, w_pop;
    logic             r_hit, b_hit;

    nasti_mux_rr #(.N(N_MASTER), .IW(IDX_W)) u_ar_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (master_ar_valid),
        .en      (1'b1),
        .hs      (slave_ar_valid && slave_ar_ready),
        .gnt     (ar_gnt),
        .gnt_vld (ar_gnt_vld)
    );

    // AW may only win a new grant while the W FIFO has room for its index.
    nasti_mux_rr #(.N(N_MASTER), .IW(IDX_W)) u_aw_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (master_aw_valid),
        .en      (!w_full),
        .hs      (slave_aw_valid && slave_aw_ready),
        .gnt     (aw_gnt),
        .gnt_vld (aw_gnt_vld)
    );

    assign w_push = slave_aw_valid && slave_aw_ready;
    assign w_pop  = slave_w_valid && slave_w_ready && slave_w_last;

    nasti_mux_fifo #(.W(IDX_W), .DEPTH(W_FIFO_DEPTH)) u_w_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .push_dat (aw_gnt),
        .pop      (w_pop),
        .head_dat (w_head),
        .full     (w_full),
        .empty    (w_empty)
    );

    // AR channel
    assign slave_ar_valid  = !rst && ar_gnt_vld && master_ar_valid[ar_gnt];
    assign slave_ar_id     = {ar_gnt, master_ar_id[ar_gnt]};
    assign slave_ar_addr   = master_ar_addr[ar_gnt];
    assign slave_ar_len    = master_ar_len[ar_gnt];
    assign slave_ar_size   = master_ar_size[ar_gnt];
    assign slave_ar_burst  = master_ar_burst[ar_gnt];
    assign slave_ar_lock   = master_ar_lock[ar_gnt];
    assign slave_ar_cache  = master_ar_cache[ar_gnt];
    assign slave_ar_prot   = master_ar_prot[ar_gnt];
    assign slave_ar_qos    = master_ar_qos[ar_gnt];
    assign slave_ar_region = master_ar_region[ar_gnt];
    assign slave_ar_user   = master_ar_user[ar_gnt];

    // AW channel
    assign slave_aw_valid  = !rst && aw_gnt_vld && master_aw_valid[aw_gnt];
    assign slave_aw_id     = {aw_gnt, master_aw_id[aw_gnt]};
    assign slave_aw_addr   = master_aw_addr[aw_gnt];
    assign slave_aw_len    = master_aw_len[aw_gnt];
    assign slave_aw_size   = master_aw_size[aw_gnt];
    assign slave_aw_burst  = master_aw_burst[aw_gnt];
    assign slave_aw_lock   = master_aw_lock[aw_gnt];
    assign slave_aw_cache  = master_aw_cache[aw_gnt];
    assign slave_aw_prot   = master_aw_prot[aw_gnt];
    assign slave_aw_qos    = master_aw_qos[aw_gnt];
    assign slave_aw_region = master_aw_region[aw_gnt];
    assign slave_aw_user   = master_aw_user[aw_gnt];

    // W channel follows the oldest granted AW
    assign w_act         = !rst && !w_empty;
    assign slave_w_valid = w_act && master_w_valid[w_head];
    assign slave_w_data  = master_w_data[w_head];
    assign slave_w_strb  = master_w_strb[w_head];
    assign slave_w_last  = master_w_last[w_head];
    assign slave_w_user  = master_w_user[w_head];

    // Responses are routed by the index bits prepended to the ID; unknown indices are sunk.
    assign r_idx = slave_r_id[SID_W-1:ID_WIDTH];
    assign b_idx = slave_b_id[SID_W-1:ID_WIDTH];
    assign r_hit = (32'(r_idx) < N_MASTER);
    assign b_hit = (32'(b_idx) < N_MASTER);

    always_comb begin
        master_ar_ready = '0;
        master_aw_ready = '0;
        master_w_ready  = '0;
        master_r_valid  = '0;
        master_b_valid  = '0;
        if (!rst && ar_gnt_vld) master_ar_ready[ar_gnt] = slave_ar_ready;
        if (!rst && aw_gnt_vld) master_aw_ready[aw_gnt] = slave_aw_ready;
        if (w_act)              master_w_ready[w_head]  = slave_w_ready;
        if (!rst && r_hit)      master_r_valid[r_idx]   = slave_r_valid;
        if (!rst && b_hit)      master_b_valid[b_idx]   = slave_b_valid;
    end

    assign slave_r_ready = !rst && (r_hit ? master_r_ready[r_idx] : 1'b1);
    assign slave_b_ready = !rst && (b_hit ? master_b_ready[b_idx] : 1'b1);

    assign master_r_id   = {N_MASTER{slave_r_id[ID_WIDTH-1:0]}};
    assign master_r_data = {N_MASTER{slave_r_data}};
    assign master_r_resp = {N_MASTER{slave_r_resp}};
    assign master_r_last = {N_MASTER{slave_r_last}};
    assign master_r_user = {N_MASTER{slave_r_user}};
    assign master_b_id   = {N_MASTER{slave_b_id[ID_WIDTH-1:0]}};
    assign master_b_resp = {N_MASTER{slave_b_resp}};
    assign master_b_user = {N_MASTER{slave_b_user}};
endmodule
